// File: rtl/cascade_event_receiver_if.sv
// Bundle between the cascade arbiter root / event consumer and the receiver.
// The receiver connects through the slave modport; the arbiter and consumer side uses master.
interface cascade_event_receiver_if #(
  parameter int N_ENTRIES  = 32,
  parameter int FIFO_DEPTH = 8
) ();
  localparam int IDX_W = $clog2(N_ENTRIES);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic                 req_in;
  logic [N_ENTRIES-1:0] grant_in;
  logic                 ack_out;
  logic                 evt_valid;
  logic                 evt_ready;
  logic [IDX_W-1:0]     evt_index;
  logic                 evt_err;
  logic [LVL_W-1:0]     fifo_level;

  modport master (
    output req_in, grant_in, evt_ready,
    input  ack_out, evt_valid, evt_index, evt_err, fifo_level
  );

  modport slave (
    input  req_in, grant_in, evt_ready,
    output ack_out, evt_valid, evt_index, evt_err, fifo_level
  );
endinterface

// File: rtl/cascade_event_receiver.sv
// Clocked 4-phase responder for the async cascade arbiter: it synchronises req, decodes the
// one-hot grant and queues winning indices in a FIFO; back-pressure works by withholding ack.
module cascade_event_receiver #(
  parameter int N_ENTRIES   = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  cascade_event_receiver_if.slave  bus,
  output logic                     err_sticky,
  input  logic                     err_clr
);
  localparam int IDX_W = $clog2(N_ENTRIES);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, ACK, RELEASE} state_t;

  state_t                 state_q, state_d;
  logic                   ack_q, ack_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]       level_q, level_d;
  logic                   err_q, err_d;
  logic [IDX_W:0]         mem_q [FIFO_DEPTH];
  logic [IDX_W:0]         mem_d [FIFO_DEPTH];

  logic                   req_s;
  logic [IDX_W-1:0]       dec_idx;
  logic                   dec_err;
  logic                   empty, full, pop, push;

  assign req_s = sync_q[SYNC_STAGES-1];
  assign empty = (level_q == '0);
  assign full  = (level_q == LVL_W'(FIFO_DEPTH));
  assign pop   = !empty && bus.evt_ready;

  // Lowest set bit wins so that a malformed grant still yields a deterministic index.
  always_comb begin
    dec_idx = '0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (bus.grant_in[i]) dec_idx = IDX_W'(i);
    end
    dec_err = (bus.grant_in == '0) ||
              ((bus.grant_in & (bus.grant_in - N_ENTRIES'(1))) != '0);
  end

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_s && (!full || pop)) begin
          push    = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        if (!req_s) state_d = RELEASE;
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ack_d = (state_d == ACK);
  end

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], bus.req_in};
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    err_d    = err_q;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = {dec_err, dec_idx};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (pop && !push) level_d = level_q - 1'b1;
    // A new error outranks a clear arriving in the same cycle.
    if (err_clr)           err_d = 1'b0;
    if (push && dec_err)   err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ack_q    <= 1'b0;
      sync_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      sync_q   <= sync_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      err_q    <= err_d;
      mem_q    <= mem_d;
    end
  end

  assign bus.ack_out    = ack_q;
  assign bus.evt_valid  = !empty;
  assign bus.evt_index  = empty ? '0 : mem_q[rd_ptr_q][IDX_W-1:0];
  assign bus.evt_err    = empty ? 1'b0 : mem_q[rd_ptr_q][IDX_W];
  assign bus.fifo_level = level_q;
  assign err_sticky     = err_q;
endmodule

// File: tb/tb_cascade_event_receiver.sv
// Scoreboard bench for cascade_event_receiver: expected events are queued when a handshake
// is driven and compared against the FIFO head whenever the consumer pops.
module tb_cascade_event_receiver;
  localparam int N_ENTRIES  = 32;
  localparam int FIFO_DEPTH = 8;

  logic clk;
  logic rst_n;
  logic err_clr;
  logic err_sticky;

  int checks = 0;
  int errors = 0;
  logic [5:0] sb[$];
  bit rand_done;

  cascade_event_receiver_if #(.N_ENTRIES(N_ENTRIES), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  cascade_event_receiver #(.N_ENTRIES(N_ENTRIES), .FIFO_DEPTH(FIFO_DEPTH), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .err_sticky (err_sticky),
    .err_clr    (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitAck(input logic val, input int budget, input string tag);
    int n = 0;
    while (bus.ack_out !== val && n < budget) begin
      tick(1);
      n++;
    end
    checkOutput(tag, {31'b0, bus.ack_out}, {31'b0, val});
  endtask

  task automatic applyStimulus(input logic [31:0] grant, input int exp_idx, input bit exp_err);
    logic [4:0] idx5;
    idx5 = exp_idx[4:0];
    sb.push_back({exp_err, idx5});
    bus.grant_in = grant;
    bus.req_in   = 1'b1;
    waitAck(1'b1, 60, "ack_rise");
    bus.req_in = 1'b0;
    waitAck(1'b0, 10, "ack_fall");
  endtask

  task automatic drainFifo();
    int n = 0;
    bus.evt_ready = 1'b1;
    while (bus.evt_valid && n < 40) begin
      tick(1);
      n++;
    end
    bus.evt_ready = 1'b0;
    checkOutput("drain_level", {28'b0, bus.fifo_level}, 32'd0);
    checkOutput("sb_leftover", sb.size(), 32'd0);
  endtask

  // Consumer-side monitor: inputs change just after posedge, so negedge sees the pop decision.
  always @(negedge clk) begin
    logic [5:0] e;
    if (rst_n && bus.evt_valid && bus.evt_ready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_pop", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("pop_index", {27'b0, bus.evt_index}, {27'b0, e[4:0]});
        checkOutput("pop_err", {31'b0, bus.evt_err}, {31'b0, e[5]});
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    err_clr       = 1'b0;
    bus.req_in    = 1'b0;
    bus.grant_in  = '0;
    bus.evt_ready = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);

    checkOutput("rst_ack", {31'b0, bus.ack_out}, 32'd0);
    checkOutput("rst_valid", {31'b0, bus.evt_valid}, 32'd0);
    checkOutput("rst_level", {28'b0, bus.fifo_level}, 32'd0);
    checkOutput("rst_sticky", {31'b0, err_sticky}, 32'd0);
    checkOutput("rst_index", {27'b0, bus.evt_index}, 32'd0);
    checkOutput("rst_err", {31'b0, bus.evt_err}, 32'd0);

    // Single event with exact latency in both directions.
    sb.push_back({1'b0, 5'd5});
    bus.grant_in = 32'h1 << 5;
    bus.req_in   = 1'b1;
    tick(2);
    checkOutput("lat_ack_early", {31'b0, bus.ack_out}, 32'd0);
    tick(1);
    checkOutput("lat_ack", {31'b0, bus.ack_out}, 32'd1);
    checkOutput("lat_valid", {31'b0, bus.evt_valid}, 32'd1);
    checkOutput("lat_level", {28'b0, bus.fifo_level}, 32'd1);
    checkOutput("lat_index", {27'b0, bus.evt_index}, 32'd5);
    checkOutput("lat_err", {31'b0, bus.evt_err}, 32'd0);
    bus.req_in = 1'b0;
    tick(2);
    checkOutput("fall_ack_early", {31'b0, bus.ack_out}, 32'd1);
    tick(1);
    checkOutput("fall_ack", {31'b0, bus.ack_out}, 32'd0);
    drainFifo();

    // Fill to full, stall the ninth request, then free one slot.
    for (int i = 0; i < 8; i++) begin
      int idx;
      idx = (i % 2 == 0) ? i / 2 : 31 - i / 2;
      applyStimulus(32'h1 << idx, idx, 1'b0);
    end
    checkOutput("full_level", {28'b0, bus.fifo_level}, 32'd8);
    sb.push_back({1'b0, 5'd10});
    bus.grant_in = 32'h1 << 10;
    bus.req_in   = 1'b1;
    tick(8);
    checkOutput("stall_ack", {31'b0, bus.ack_out}, 32'd0);
    checkOutput("stall_level", {28'b0, bus.fifo_level}, 32'd8);
    checkOutput("stall_head", {27'b0, bus.evt_index}, 32'd0);
    bus.evt_ready = 1'b1;
    tick(1);
    bus.evt_ready = 1'b0;
    waitAck(1'b1, 2, "ack_after_pop");
    checkOutput("pushpop_level", {28'b0, bus.fifo_level}, 32'd8);
    checkOutput("pushpop_head", {27'b0, bus.evt_index}, 32'd31);
    bus.req_in = 1'b0;
    waitAck(1'b0, 10, "ack_fall_9th");
    drainFifo();

    // Random traffic with a concurrently toggling consumer.
    rand_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 20; k++) begin
          int idx;
          idx = $urandom_range(0, N_ENTRIES - 1);
          applyStimulus(32'h1 << idx, idx, 1'b0);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          tick(1);
          bus.evt_ready = ($urandom_range(0, 1) == 1);
        end
      end
    join
    drainFifo();

    // Malformed grants still handshake and flag an error.
    applyStimulus(32'h0000_0006, 1, 1'b1);
    checkOutput("bad_sticky", {31'b0, err_sticky}, 32'd1);
    checkOutput("bad_head_idx", {27'b0, bus.evt_index}, 32'd1);
    checkOutput("bad_head_err", {31'b0, bus.evt_err}, 32'd1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    checkOutput("clr_sticky", {31'b0, err_sticky}, 32'd0);
    applyStimulus(32'h0, 0, 1'b1);
    checkOutput("zero_sticky", {31'b0, err_sticky}, 32'd1);
    drainFifo();

    // Asynchronous reset while ack is high.
    sb.push_back({1'b0, 5'd7});
    bus.grant_in = 32'h1 << 7;
    bus.req_in   = 1'b1;
    waitAck(1'b1, 10, "mid_ack_rise");
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_ack", {31'b0, bus.ack_out}, 32'd0);
    checkOutput("mid_rst_level", {28'b0, bus.fifo_level}, 32'd0);
    checkOutput("mid_rst_sticky", {31'b0, err_sticky}, 32'd0);
    sb.delete();
    bus.req_in = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    applyStimulus(32'h1 << 9, 9, 1'b0);
    checkOutput("post_rst_level", {28'b0, bus.fifo_level}, 32'd1);
    drainFifo();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout got %0d expected %0d", 1, 0);
    $fatal(1, "[TB] timeout");
  end
endmodule
